// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program-counter register and instruction-fetch sequencer with a
//             req/ack memory handshake, in-flight redirect and ack timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned INC        = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_ALU,
    input  logic        S_MXPC,
    input  logic        W_PC,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] out_PC,
    output logic [31:0] out_ADD,
    output logic        instr_valid,
    output logic        fetch_err
);

    localparam int unsigned c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [31:0]        c_INC      = 32'(INC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]         r_state,  w_state_nxt;
    logic [31:0]        r_pc,     w_pc_nxt;
    logic [31:0]        r_target, w_target_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic               r_req,    w_req_nxt;
    logic               r_valid,  w_valid_nxt;
    logic               r_err,    w_err_nxt;
    logic               r_pend,   w_pend_nxt;
    logic [31:0]        w_add;
    logic               w_ack;
    logic               w_flush;

    assign w_add   = r_pc + c_INC;
    // An ack only counts while a request is actually outstanding.
    assign w_ack   = r_req & imem_ack;
    assign w_flush = W_PC & S_MXPC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_ADDR;
            r_target <= RESET_ADDR;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_req    <= w_req_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_req_nxt    = r_req;
        w_valid_nxt  = r_valid;
        w_err_nxt    = r_err;
        w_pend_nxt   = r_pend;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_flush) begin
                    w_pend_nxt   = 1'b1;
                    w_target_nxt = in_ALU;
                end
                if (!r_req) begin
                    // Issue (or re-issue after a timeout) the request.
                    w_req_nxt = 1'b1;
                    w_cnt_nxt = '0;
                end else if (w_ack) begin
                    w_cnt_nxt = '0;
                    if (w_flush || r_pend) begin
                        // Drop the returned instruction and refetch at the target.
                        w_pc_nxt   = w_flush ? in_ALU : r_target;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_READY;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err_nxt = 1'b1;
                    w_req_nxt = 1'b0;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_READY: begin
                if (W_PC) begin
                    w_pc_nxt    = S_MXPC ? in_ALU : w_add;
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign out_PC      = r_pc;
    assign out_ADD     = w_add;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Randomized scoreboard bench for pc_fetch_unit with a
//             transaction-level model of the expected PC stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] RST_ADDR = 32'hFFFF_FFFC;
    localparam logic [31:0] STEP     = 32'd4;
    localparam int          TMO      = 16;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_READY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_ALU = '0;
    logic        S_MXPC = 1'b0;
    logic        W_PC = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] out_PC;
    logic [31:0] out_ADD;
    logic        instr_valid;
    logic        fetch_err;

    pc_fetch_unit #(
        .RESET_ADDR (RST_ADDR),
        .INC        (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_ALU      (in_ALU),
        .S_MXPC      (S_MXPC),
        .W_PC        (W_PC),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .out_PC      (out_PC),
        .out_ADD     (out_ADD),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: PC stream expected at decode, current PC, pending target.
    logic [31:0] q[$];
    int          m_state  = M_IDLE;
    logic [31:0] m_pc     = RST_ADDR;
    logic [31:0] m_target = RST_ADDR;
    logic        m_pend   = 1'b0;
    logic        m_valid  = 1'b0;
    int          wait_cnt = 0;
    bit          tmo_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    // Monitor: compares every cycle against the model and pops the scoreboard
    // whenever a new instruction is presented to decode.
    initial begin
        logic prev_valid;
        logic [31:0] exp;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            check("out_pc", out_PC, m_pc);
            check("imem_addr", imem_addr, m_pc);
            check("out_add", out_ADD, m_pc + STEP);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            if (instr_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check("delivered_pc", out_PC, exp);
                end
            end
            prev_valid = instr_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        q.delete();
        m_state  = M_IDLE;
        m_pc     = RST_ADDR;
        m_target = RST_ADDR;
        m_pend   = 1'b0;
        m_valid  = 1'b0;
        wait_cnt = 0;
        rst      = 1'b1;
        W_PC     = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("rst_pc", out_PC, RST_ADDR);
        check("rst_add_wrap", out_ADD, 32'h0000_0000);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        m_state = M_FETCH;
        #1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_ADDR);
        q.push_back(RST_ADDR);
    endtask

    // Starve the current request and watch the timeout/retry sequence.
    task automatic run_timeout();
        int  n;
        bit  dropped;
        n = wait_cnt;
        dropped = 1'b0;
        for (int k = 0; k < 4 * TMO && !dropped; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            W_PC     = 1'b0;
            if (imem_req) n++;
            else if (n > 0) dropped = 1'b1;
        end
        check("tmo_seen", {31'd0, dropped}, 32'd1);
        check("tmo_cycles", n, TMO);
        check("tmo_err", {31'd0, fetch_err}, 32'd1);
        check("tmo_req_drop", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("tmo_rereq", {31'd0, imem_req}, 32'd1);
        check("tmo_addr", imem_addr, m_pc);
        wait_cnt = 0;
    endtask

    task automatic run_cycles(input int n, input int tmo_at);
        logic [31:0] nxt;
        bit          flush;
        bit          acc;
        bit          req_s;
        int          r;
        for (int i = 0; i < n; i++) begin
            if (tmo_at >= 0 && !tmo_done && i >= tmo_at && m_state == M_FETCH) begin
                run_timeout();
                tmo_done = 1'b1;
            end
            @(negedge clk);
            W_PC     = 1'b0;
            S_MXPC   = 1'($urandom_range(0, 1));
            in_ALU   = rand_addr();
            imem_ack = 1'b0;
            flush    = 1'b0;
            acc      = 1'b0;
            req_s    = imem_req;
            if (m_state == M_READY) begin
                if ($urandom_range(0, 1) == 1) begin
                    W_PC     = 1'b1;
                    nxt      = S_MXPC ? in_ALU : m_target + STEP;
                    m_target = nxt;
                    q.push_back(nxt);
                end
            end else if (m_state == M_FETCH) begin
                if (req_s) begin
                    imem_ack = (wait_cnt >= 8) || ($urandom_range(0, 2) == 0);
                    acc      = imem_ack;
                end
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    W_PC     = 1'b1;
                    S_MXPC   = 1'b1;
                    flush    = 1'b1;
                    m_target = in_ALU;
                    if (q.size() > 0) q[q.size() - 1] = in_ALU;
                end else if (r == 1) begin
                    W_PC   = 1'b1;
                    S_MXPC = 1'b0;
                end
            end
            @(posedge clk);
            if (m_state == M_READY && W_PC) begin
                m_state  = M_FETCH;
                m_valid  = 1'b0;
                m_pc     = m_target;
                wait_cnt = 0;
            end else if (m_state == M_FETCH) begin
                if (acc) begin
                    wait_cnt = 0;
                    if (flush || m_pend) begin
                        m_pend = 1'b0;
                        m_pc   = m_target;
                    end else begin
                        m_state = M_READY;
                        m_valid = 1'b1;
                    end
                end else begin
                    if (req_s) wait_cnt++;
                    if (flush) m_pend = 1'b1;
                end
            end
        end
    endtask

    initial begin
        do_reset();
        run_cycles(600, 200);
        check("tmo_happened", {31'd0, tmo_done}, 32'd1);
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        // Land the reset in the middle of an outstanding request.
        for (int k = 0; k < 50 && !(m_state == M_FETCH && imem_req); k++)
            run_cycles(1, -1);
        check("midrst_precond", {31'd0, imem_req}, 32'd1);
        do_reset();
        run_cycles(600, -1);
        check("err_clear", {31'd0, fetch_err}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and fetch sequencer; the consumer end of the PC-select path.
- Holds current PC and issues fetch requests to instruction memory over a req/ack handshake.
- Produces PC+INC as the sequential-path candidate, and takes the ALU branch target with its select S_MXPC.
- Sits between the PC-select mux stage and instruction memory, feeding the decode stage.

Parameters:
- RESET_ADDR, 32'h00000000: PC value loaded on reset.
- INC, 4: sequential increment added to PC for out_ADD.
- TIMEOUT, 16: max cycles waiting for imem_ack before flagging an error and retrying (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_ALU  in  32  branch/jump target.
- S_MXPC  in  1  1 = next PC is in_ALU; 0 = next PC is out_ADD.
- W_PC  in  1  advance enable from control; pipeline consumed current instruction.
- imem_ack  in  1  instruction memory accepted request; instruction valid this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals out_PC.
- out_PC  out  32  current PC register.
- out_ADD  out  32  out_PC + INC, combinational, modulo 2^32.
- instr_valid  out  1  fetched instruction held and ready for decode.
- fetch_err  out  1  sticky; set on ack timeout, cleared only by rst.

Behaviour:
- Reset (async, immediate): out_PC=RESET_ADDR, imem_req=0, instr_valid=0, fetch_err=0, state=IDLE, wait counter=0, redirect pending=0.
- States: IDLE, FETCH, READY.
- IDLE: one cycle after rst deasserts, then FETCH. imem_req=0.
- FETCH:
  - imem_req=1 and imem_addr=out_PC, both registered and stable until ack.
  - Wait counter increments each cycle without ack.
  - On imem_ack with no pending redirect: go to READY, instr_valid=1 on the next cycle (1-cycle latency from ack). The request drops in the same edge.
  - On imem_ack with pending redirect: discard fetch (instr_valid stays 0), out_PC <= latched target, clear pending, remain in FETCH with a new request the next cycle.
  - W_PC=1 with S_MXPC=1 while in FETCH (flush): latch in_ALU as pending target. A later redirect before ack overwrites it. W_PC=1 with S_MXPC=0 in FETCH is ignored.
  - Timeout: if counter reaches TIMEOUT-1 without ack, set fetch_err. Deassert imem_req for one cycle, reset counter, re-request the same address.
- READY:
  - instr_valid=1, imem_req=0.
  - On W_PC=1: out_PC <= S_MXPC ? in_ALU : out_ADD, instr_valid <= 0, state FETCH.
  - On W_PC=0: hold all outputs.
- Arithmetic: out_ADD wraps. 32'hFFFFFFFC + 4 = 32'h00000000, no carry flag.
- Simultaneous imem_ack with flush W_PC/S_MXPC in FETCH: the flush wins. Fetch is discarded and the new target is fetched.
- Timeout and ack on the same cycle: ack wins, no error.
- rst asserted mid-fetch: request drops immediately, and any outstanding ack after reset is ignored.
- out_PC changes only on W_PC in READY, on a redirect apply, or on reset.

Test Plan:
- Reset: rst=1 → out_PC=0, imem_req=0, instr_valid=0. Release → imem_req=1 two edges later, imem_addr=0.
- Sequential: ack at addr 0, W_PC=1, S_MXPC=0 → out_PC=4, new req addr=4. Repeat → 8. out_ADD always out_PC+4.
- Branch: in READY at PC=8, in_ALU=32'h00000100, S_MXPC=1, W_PC=1 → out_PC=0x100, imem_addr=0x100.
- Flush in flight: in FETCH at PC=0x10, W_PC=1 with S_MXPC=1 and in_ALU=0x200, then ack → instr_valid stays 0, next req addr=0x200. Also apply the flush coincident with ack → same result.
- Timeout: TIMEOUT=16, hold imem_ack=0 → fetch_err=1 after 16 cycles, req drops one cycle then re-asserts with the same addr. Subsequent ack → READY, fetch_err stays 1.
- Wrap and reset mid-op: RESET_ADDR=32'hFFFFFFFC, advance → out_PC=0. Assert rst during FETCH → outputs at reset values the same cycle.
